// File: rtl/yutorina_decode_stage.sv
// Yutorina decode stage: decodes R and I arithmetic instructions into a registered
// ALU bundle with EX/WB operand forwarding, RAW stall, flush and illegal flagging.
module yutorina_decode_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ENABLE_FORWARD = 1
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instruction,
    output logic [4:0]            left_register_read_address,
    output logic [4:0]            right_register_read_address,
    input  logic [DATA_WIDTH-1:0] left_register_read_data,
    input  logic [DATA_WIDTH-1:0] right_register_read_data,
    input  logic                  ex_write_enable_,
    input  logic [4:0]            ex_write_address,
    input  logic                  ex_result_valid,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic                  wb_write_enable_,
    input  logic [4:0]            wb_write_address,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            alu_opcode,
    output logic [4:0]            result_register_address,
    output logic [DATA_WIDTH-1:0] lhs,
    output logic [DATA_WIDTH-1:0] rhs,
    output logic                  register_write_enable_,
    output logic                  illegal
);

    localparam logic FWD = (ENABLE_FORWARD != 0);

    logic [5:0]            w_op;
    logic [4:0]            w_rd;
    logic [4:0]            w_rs1;
    logic [4:0]            w_rs2;
    logic                  w_is_r;
    logic                  w_is_i;
    logic                  w_use_rs1;
    logic                  w_use_rs2;
    logic [DATA_WIDTH-1:0] w_imm;

    assign w_op   = instruction[31:26];
    assign w_rd   = instruction[25:21];
    assign w_rs1  = instruction[20:16];
    assign w_rs2  = instruction[15:11];
    assign w_is_r = (w_op == 6'b000000);
    assign w_is_i = instruction[31];

    // I-type never reads rs2, so its bits must not create a hazard
    assign w_use_rs1 = w_is_r | w_is_i;
    assign w_use_rs2 = w_is_r;

    assign w_imm = instruction[30] ? DATA_WIDTH'($signed(instruction[15:0]))
                                   : DATA_WIDTH'(instruction[15:0]);

    assign left_register_read_address  = w_rs1;
    assign right_register_read_address = w_rs2;

    logic w_ex_hit_l;
    logic w_ex_hit_r;
    logic w_wb_hit_l;
    logic w_wb_hit_r;
    logic w_nz_l;
    logic w_nz_r;

    assign w_nz_l     = (w_rs1 != 5'd0);
    assign w_nz_r     = (w_rs2 != 5'd0);
    assign w_ex_hit_l = w_nz_l && !ex_write_enable_ && (ex_write_address == w_rs1);
    assign w_ex_hit_r = w_nz_r && !ex_write_enable_ && (ex_write_address == w_rs2);
    assign w_wb_hit_l = w_nz_l && !wb_write_enable_ && (wb_write_address == w_rs1);
    assign w_wb_hit_r = w_nz_r && !wb_write_enable_ && (wb_write_address == w_rs2);

    // EX beats WB; WB beats the register file, which may still be stale this cycle
    logic [DATA_WIDTH-1:0] w_src_l;
    logic [DATA_WIDTH-1:0] w_src_r;

    assign w_src_l = (FWD && w_ex_hit_l && ex_result_valid) ? ex_result :
                     (FWD && w_wb_hit_l)                    ? wb_result :
                                                              left_register_read_data;
    assign w_src_r = (FWD && w_ex_hit_r && ex_result_valid) ? ex_result :
                     (FWD && w_wb_hit_r)                    ? wb_result :
                                                              right_register_read_data;

    logic w_haz_l;
    logic w_haz_r;
    logic w_stall;

    assign w_haz_l = (w_ex_hit_l && (!ex_result_valid || !FWD)) || (!FWD && w_wb_hit_l);
    assign w_haz_r = (w_ex_hit_r && (!ex_result_valid || !FWD)) || (!FWD && w_wb_hit_r);
    assign w_stall = in_valid && ((w_use_rs1 && w_haz_l) || (w_use_rs2 && w_haz_r));

    logic r_valid;

    assign in_ready = flush | ((!r_valid | out_ready) & !w_stall);

    logic [3:0]            w_dec_opcode;
    logic [4:0]            w_dec_rd;
    logic [DATA_WIDTH-1:0] w_dec_lhs;
    logic [DATA_WIDTH-1:0] w_dec_rhs;
    logic                  w_dec_we_;
    logic                  w_dec_illegal;

    always_comb begin
        w_dec_opcode  = 4'd0;
        w_dec_rd      = 5'd0;
        w_dec_lhs     = '0;
        w_dec_rhs     = '0;
        w_dec_we_     = 1'b1;
        w_dec_illegal = 1'b0;
        if (w_is_r) begin
            w_dec_opcode = instruction[3:0];
            w_dec_rd     = w_rd;
            w_dec_lhs    = w_src_l;
            w_dec_rhs    = w_src_r;
            w_dec_we_    = 1'b0;
        end else if (w_is_i) begin
            w_dec_opcode = instruction[29:26];
            w_dec_rd     = w_rd;
            w_dec_lhs    = w_src_l;
            w_dec_rhs    = w_imm;
            w_dec_we_    = 1'b0;
        end else begin
            w_dec_illegal = 1'b1;
        end
    end

    logic [3:0]            r_opcode;
    logic [4:0]            r_rd;
    logic [DATA_WIDTH-1:0] r_lhs;
    logic [DATA_WIDTH-1:0] r_rhs;
    logic                  r_we_;
    logic                  r_illegal;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_valid   <= 1'b0;
            r_opcode  <= 4'd0;
            r_rd      <= 5'd0;
            r_lhs     <= '0;
            r_rhs     <= '0;
            r_we_     <= 1'b1;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (in_valid && in_ready) begin
            r_valid   <= 1'b1;
            r_opcode  <= w_dec_opcode;
            r_rd      <= w_dec_rd;
            r_lhs     <= w_dec_lhs;
            r_rhs     <= w_dec_rhs;
            r_we_     <= w_dec_we_;
            r_illegal <= w_dec_illegal;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid               = r_valid;
    assign alu_opcode              = r_opcode;
    assign result_register_address = r_rd;
    assign lhs                     = r_lhs;
    assign rhs                     = r_rhs;
    assign register_write_enable_  = r_we_;
    assign illegal                 = r_illegal;

endmodule

// File: doc/yutorina_decode_stage.md
# yutorina_decode_stage

Registered, parametrised decode stage for the Yutorina pipeline. It sits between fetch and the ALU/execute stage. It decodes arithmetic and arithmetic-immediate instructions into ALU opcode, operands and writeback controls. Beyond a combinational decoder, it adds a valid/ready pipeline register, operand forwarding from EX and WB, a RAW-hazard stall, flush, and illegal-instruction flagging.

## Interface
- DATA_WIDTH, 32: operand/result width; must be ≥16; the immediate extends to this width
- ENABLE_FORWARD, 1: 1 = forward from EX/WB; 0 = always use register-file data and stall on any pending-write match
- clk  in  1  clock
- reset_  in  1  synchronous, active-low reset
- flush  in  1  discard the held and incoming instruction
- in_valid  in  1  instruction valid from fetch
- in_ready  out  1  stage accepts the instruction this cycle
- instruction  in  32  instruction word
- left_register_read_address / right_register_read_address  out  5  combinational from `instruction`
- left_register_read_data / right_register_read_data  in  DATA_WIDTH  register-file read data, same cycle
- ex_write_enable_  in  1  EX holds a register write (active-low)
- ex_write_address  in  5  EX destination
- ex_result_valid  in  1  EX result is available this cycle
- ex_result  in  DATA_WIDTH  EX result
- wb_write_enable_ / wb_write_address / wb_result  in  1/5/DATA_WIDTH  WB write port
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- alu_opcode  out  4  ALU function
- result_register_address  out  5  destination register
- lhs / rhs  out  DATA_WIDTH  ALU operands
- register_write_enable_  out  1  active-low writeback enable
- illegal  out  1  the held instruction was illegal

## Operation
Decode fields:
- op = instruction[31:26].
- Arithmetic (R): op == 6'b000000.
  - alu_opcode = instruction[3:0].
  - rd = [25:21], rs1 = [20:16], rs2 = [15:11].
  - lhs = rs1 value, rhs = rs2 value.
- Arithmetic-immediate (I): instruction[31] == 1.
  - alu_opcode = instruction[29:26].
  - Immediate = instruction[15:0], sign-extended to DATA_WIDTH when instruction[30] == 1, otherwise zero-extended.
  - lhs = rs1 value, rhs = immediate.
- Any other op is illegal.
  - Bundle is a NOP: alu_opcode 0, lhs = rhs = 0, register_write_enable_ = 1, illegal = 1.
- R and I both set register_write_enable_ = 0 (enabled).

Operand source, per used source register r:
- r == 0: use register-file data, never forwarded.
- Otherwise, when ENABLE_FORWARD is 1, priority is:
  1. ex_result, if ex_write_enable_ == 0 and ex_write_address == r and ex_result_valid.
  2. wb_result, if wb_write_enable_ == 0 and wb_write_address == r.
  3. Register-file data.
- I-type uses only rs1; rs2 bits never cause a hazard.

Hazard stall:
- stall = in_valid & a used r ≠ 0 matches ex_write_address, with ex_write_enable_ == 0 and (!ex_result_valid or ENABLE_FORWARD == 0).
- When ENABLE_FORWARD == 0, a WB match also stalls.

Handshake:
- in_ready = flush | ((!out_valid | out_ready) & !stall).
- Accept when in_valid & in_ready & !flush: load the bundle, out_valid ← 1.
- Else if out_ready: out_valid ← 0.
- When out_valid & !out_ready, all output registers hold stable.
- flush: out_valid ← 0, illegal ← 0, and the incoming instruction is consumed and dropped. Flush has priority over accept and stall.

## Timing
- Reset (reset_ low at a clk edge):
  - out_valid = 0, alu_opcode = 0, result_register_address = 0, lhs = rhs = 0.
  - register_write_enable_ = 1, illegal = 0.
  - in_ready follows its equation (out_valid = 0, so it is 1 unless stalling).
- Latency: 1 cycle from an accepted instruction to out_valid.
- Throughput: 1 instruction/cycle while out_ready = 1 and there is no stall.
- Read addresses, stall and in_ready are combinational. All bundle outputs come from flops.
- The forward mux samples EX/WB in the accept cycle. A value written by WB in that same cycle is taken from wb_result, not from the stale register file.
- A stall lasts until ex_result_valid rises or the EX write leaves EX. The bundle is accepted in the first non-stall cycle.
- Simultaneous EX and WB match on the same r: EX wins.
- Backpressure while stalled: both conditions must clear before acceptance.
- Flush while out_valid & !out_ready: the bundle is dropped next cycle.

## Test plan
- Reset, then R-type with op 0, rd 3, rs1 1, rs2 2, func 4'h2; regfile r1 = 5, r2 = 7 → next cycle out_valid = 1, alu_opcode 2, lhs 5, rhs 7, rd 3, register_write_enable_ 0.
- I-type with bit30 = 1, imm 16'hFFFE, rs1 = 0 → rhs 32'hFFFFFFFE, lhs = regfile r0. Same with bit30 = 0 → rhs 32'h0000FFFE.
- EX writes r1 = 9 (valid) and WB writes r1 = 4; decode rs1 = r1 → lhs 9. With EX idle instead → lhs 4. rs1 = r0 with EX writing r0 → no forward.
- EX writes r2 with ex_result_valid low for 3 cycles; R-type reads r2 → in_ready 0 for 3 cycles, then accepted. lhs/rhs take ex_result at the accept cycle, out_valid the cycle after.
- out_ready held 0 for 4 cycles with a held bundle → outputs stable, in_ready 0. Assert flush → out_valid 0 next cycle, in_ready 1 during flush.
- op 6'b010000 → illegal 1, register_write_enable_ 1, alu_opcode 0. Assert reset_ = 0 mid-stream → all outputs at reset values next edge.
